// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and sizing helper for seq_mult_param
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Bits needed to hold a step count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// rtl/seq_mult_datapath.sv - shift-add datapath: operand magnitudes, accumulator, sign fix, product register
// Early-termination shifter is built only when SEQ_MULT_EARLY_TERM_EN is defined.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               tc,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               cnt_zero,
  output logic               rem_zero,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0]   acc, mq, mcand;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [WIDTH-1:0]   x_mag, y_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // The most negative operand maps onto 2^(WIDTH-1), which still fits unsigned.
  assign x_mag = (tc && x[WIDTH-1]) ? (~x + 1'b1) : x;
  assign y_mag = (tc && y[WIDTH-1]) ? (~y + 1'b1) : y;

  assign sum  = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign prod = {acc, mq};

  // Asserted on the step that brings cnt down to zero.
  assign cnt_zero = (cnt == CW'(1));

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask = ~({WIDTH{1'b1}} << cnt);
  assign rem_zero = ((mq & rem_mask) == '0);
`else
  assign rem_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
    end else begin
      if (load) begin
        acc   <= '0;
        mq    <= y_mag;
        mcand <= x_mag;
        cnt   <= CW'(WIDTH);
        neg   <= tc & (x[WIDTH-1] ^ y[WIDTH-1]);
      end else if (step) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (rem_zero) begin
          {acc, mq} <= {acc, mq} >> cnt;
          cnt       <= '0;
        end else begin
          {acc, mq} <= {sum, mq[WIDTH-1:1]};
          cnt       <= cnt - 1'b1;
        end
`else
        {acc, mq} <= {sum, mq[WIDTH-1:1]};
        cnt       <= cnt - 1'b1;
`endif
      end
      if (fix) begin
        p <= neg ? -prod : prod;
      end
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// rtl/seq_mult_param.sv - parametrised sequential shift-add multiplier, unsigned or two's complement
// Optional early termination on zero remaining multiplier bits: SEQ_MULT_EARLY_TERM_EN.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic [2*WIDTH-1:0] p,
  output logic               out_en
);

  state_t state, state_n;
  logic   load, step, fix;
  logic   cnt_zero, rem_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      out_en <= 1'b0;
    end else begin
      state  <= state_n;
      out_en <= (state == FIX);
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_zero || rem_zero) state_n = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .fix      (fix),
    .tc       (tc),
    .x        (x),
    .y        (y),
    .cnt_zero (cnt_zero),
    .rem_zero (rem_zero),
    .p        (p)
  );

endmodule

// File: tb/tb_seq_mult_param.sv
// tb/tb_seq_mult_param.sv - self-checking bench for seq_mult_param at WIDTH 4, 8 and 24
// Expected latency follows SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_s, tc_s, busy_s, oen_s;
  logic [3:0]  x4, y4;
  logic [7:0]  x8, y8, p4_dummy;
  logic [23:0] x24, y24;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [47:0] p24;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_s[0]), .tc(tc_s[0]), .x(x4), .y(y4),
    .busy(busy_s[0]), .p(p4), .out_en(oen_s[0]));
  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start_s[1]), .tc(tc_s[1]), .x(x8), .y(y8),
    .busy(busy_s[1]), .p(p8), .out_en(oen_s[1]));
  seq_mult_param #(.WIDTH(24)) dut24 (
    .clk(clk), .reset(reset), .start(start_s[2]), .tc(tc_s[2]), .x(x24), .y(y24),
    .busy(busy_s[2]), .p(p24), .out_en(oen_s[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operand value as an integer under the selected interpretation.
  function automatic longint as_int(input int w, input bit tcv, input logic [23:0] v);
    longint a;
    a = longint'(v) & ((longint'(1) << w) - 1);
    if (tcv && a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
    return a;
  endfunction

  function automatic longint ref_prod(input int w, input bit tcv, input logic [23:0] xv, input logic [23:0] yv);
    longint r;
    r = as_int(w, tcv, xv) * as_int(w, tcv, yv);
    return r & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Edges from the start edge until out_en is visible.
  function automatic int ref_lat(input int w, input bit tcv, input logic [23:0] yv);
`ifdef SEQ_MULT_EARLY_TERM_EN
    longint m;
    int h;
    m = as_int(w, tcv, yv);
    if (m < 0) m = -m;
    if (m == 0) return 2;
    h = 0;
    for (int i = 0; i < w; i++) if (m[i]) h = i;
    // Bits 0..h are stepped one per edge; a collapse edge follows unless bit w-1 was the last.
    return (h == w - 1) ? (w + 1) : (h + 3);
`else
    return w + 1;
`endif
  endfunction

  task automatic run_op(input int sel, input bit tcv, input logic [23:0] xv, input logic [23:0] yv,
                        input string tag);
    int w, edges, busy_cnt;
    bit got;
    logic [63:0] pv;
    w = (sel == 0) ? 4 : ((sel == 1) ? 8 : 24);
    case (sel)
      0: begin x4 = xv[3:0]; y4 = yv[3:0]; end
      1: begin x8 = xv[7:0]; y8 = yv[7:0]; end
      default: begin x24 = xv; y24 = yv; end
    endcase
    tc_s[sel] = tcv;
    start_s[sel] = 1'b1;
    edges = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (edges < 200 && !got) begin
      @(negedge clk);
      edges++;
      if (edges == 1) start_s[sel] = 1'b0;
      if (busy_s[sel]) busy_cnt++;
      if (oen_s[sel]) got = 1'b1;
    end
    check({tag, "_done"}, 64'(got), 64'(1));
    case (sel)
      0: pv = 64'(p4);
      1: pv = 64'(p8);
      default: pv = 64'(p24);
    endcase
    check({tag, "_p"}, pv, 64'(ref_prod(w, tcv, xv, yv)));
    check({tag, "_lat"}, 64'(edges - 1), 64'(ref_lat(w, tcv, yv)));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(ref_lat(w, tcv, yv)));
  endtask

  initial begin
    int pulses, n;
    logic [23:0] rx, ry;
    int sel;
    bit rtc;
    p4_dummy = '0;
    reset = 1'b1;
    start_s = '0; tc_s = '0;
    x4 = '0; y4 = '0; x8 = '0; y8 = '0; x24 = '0; y24 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_s), 64'(0));
    check("rst_out_en", 64'(oen_s), 64'(0));
    check("rst_p24", 64'(p24), 64'(0));
    check("rst_p8", 64'(p8), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run_op(2, 1'b0, 24'hFFFFFF, 24'hFFFFFF, "u_ff_ff");
    check("u_ff_ff_const", 64'(p24), 64'h0000_FFFF_FE00_0001);
    run_op(2, 1'b1, 24'hFFFFFD, 24'h000005, "s_m3_5");
    check("s_m3_5_const", 64'(p24), 64'h0000_FFFF_FFFF_FFF1);
    run_op(2, 1'b1, 24'h800000, 24'h800000, "s_min_min");
    check("s_min_min_const", 64'(p24), 64'h0000_4000_0000_0000);
    run_op(2, 1'b0, 24'h800000, 24'hFFFFFF, "u_msb");
    check("u_msb_const", 64'(p24), 64'h0000_7FFF_FF80_0000);
    run_op(2, 1'b0, 24'h123456, 24'h000000, "y_zero");
    run_op(2, 1'b0, 24'h123456, 24'h000001, "y_one");
    check("y_one_const", 64'(p24), 64'h0000_0000_0012_3456);
    run_op(2, 1'b1, 24'hFFFFFF, 24'hFFFFFF, "s_m1_m1");

    // start held high with changing operands while busy must be ignored.
    x24 = 24'h000007; y24 = 24'h800009; tc_s[2] = 1'b0; start_s[2] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      x24 = 24'($urandom);
      y24 = 24'($urandom);
    end
    start_s[2] = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (oen_s[2]) begin
        pulses++;
        check("hold_p", 64'(p24), 64'h0000_0000_0380_003F);
      end
    end
    check("hold_pulses", 64'(pulses), 64'(1));

    // Reset in the middle of CALC abandons the operation.
    x24 = 24'hABCDEF; y24 = 24'hFFFFFF; tc_s[2] = 1'b0; start_s[2] = 1'b1;
    @(negedge clk);
    start_s[2] = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 64'(busy_s[2]), 64'(0));
    check("midrst_p", 64'(p24), 64'(0));
    check("midrst_out_en", 64'(oen_s[2]), 64'(0));
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (oen_s != 3'b000) pulses++;
    end
    check("midrst_no_out", 64'(pulses), 64'(0));

    for (n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 2));
      rtc = 1'($urandom);
      rx = 24'($urandom);
      case ($urandom_range(0, 5))
        0: ry = 24'h0;
        1: ry = 24'($urandom_range(1, 15));
        2: ry = 24'hFFFFFF;
        default: ry = 24'($urandom);
      endcase
      run_op(sel, rtc, rx, ry, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
